// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state type, segment patterns and BCD decoder for the lock
package lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_SET     = 3'd4
  } state_t;

  // Active-low {dp,g,f,e,d,c,b,a}; clearing bit 7 lights the decimal point.
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] SEG_O      = 8'hC0;
  localparam logic [7:0] SEG_P      = 8'h8C;
  localparam logic [7:0] SEG_E      = 8'h86;
  localparam logic [7:0] SEG_N      = 8'hAB;
  localparam logic [7:0] SEG_R      = 8'hAF;
  localparam logic [7:0] SEG_DASH   = 8'hBF;
  localparam logic [7:0] SEG_DP_ON  = 8'h7F;

  // Whole-display messages, leftmost digit in the top byte.
  localparam logic [31:0] MSG_OPEN = {SEG_O, SEG_P, SEG_E, SEG_N};
  localparam logic [31:0] MSG_ERR  = {SEG_E, SEG_R, SEG_R, SEG_BLANK};
  localparam logic [31:0] MSG_DASH = {4{SEG_DASH}};
  localparam logic [31:0] MSG_OFF  = {4{SEG_BLANK}};

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/button_edge.sv
// rtl/button_edge.sv - two-flop synchronizer plus rising-edge one-cycle pulse
module button_edge (
  input  logic clk_100Hz,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Bring the raw button into the clock domain and keep one cycle of history.
  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // A held button yields exactly one pulse on its rising edge.
  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - code entry, lock state machine and segment drive
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE  = 16'h1234,
  parameter int          MAX_TRIES     = 3,
  parameter int          UNLOCK_TICKS  = 500,
  parameter int          FAIL_TICKS    = 100,
  parameter int          LOCKOUT_TICKS = 1000,
  parameter int          BLINK_HALF    = 25
) (
  input  logic       clk_100Hz,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       btn_next,
  input  logic       btn_enter,
  output logic [7:0] digit0,
  output logic [7:0] digit1,
  output logic [7:0] digit2,
  output logic [7:0] digit3,
  output logic       unlocked,
  output logic       alarm
);

  // Timers load T-1 on entry and leave the state when they read zero,
  // which lands the exit on the T-th edge after entry.
  localparam logic [9:0] UNLOCK_LOAD  = 10'(UNLOCK_TICKS - 1);
  localparam logic [9:0] FAIL_LOAD    = 10'(FAIL_TICKS - 1);
  localparam logic [9:0] LOCKOUT_LOAD = 10'(LOCKOUT_TICKS - 1);
  localparam logic [2:0] TRIES_LIMIT  = 3'(MAX_TRIES);
  localparam logic [1:0] CURSOR_LEFT  = 2'd3;
  localparam int         BLINK_W      = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  state_t       state;
  state_t       state_next;
  logic [15:0]  entered;
  logic [15:0]  entered_next;
  logic [15:0]  code;
  logic [15:0]  code_next;
  logic [1:0]   cursor;
  logic [1:0]   cursor_next;
  logic [1:0]   tries;
  logic [1:0]   tries_next;
  logic [9:0]   timer;
  logic [9:0]   timer_next;
  logic [BLINK_W-1:0] blink_cnt;
  logic         blink_on;

  logic         inc_p;
  logic         next_p;
  logic         enter_p;
  logic [3:0]   cur_digit;
  logic [3:0]   inc_digit;
  logic [2:0]   tries_inc;
  logic [31:0]  disp;

  button_edge u_edge_inc (
    .clk_100Hz (clk_100Hz),
    .rst       (rst),
    .btn       (btn_inc),
    .pulse     (inc_p)
  );

  button_edge u_edge_next (
    .clk_100Hz (clk_100Hz),
    .rst       (rst),
    .btn       (btn_next),
    .pulse     (next_p)
  );

  button_edge u_edge_enter (
    .clk_100Hz (clk_100Hz),
    .rst       (rst),
    .btn       (btn_enter),
    .pulse     (enter_p)
  );

  assign cur_digit = entered[{cursor, 2'b00} +: 4];
  assign inc_digit = (cur_digit >= 4'd9) ? 4'd0 : cur_digit + 4'd1;
  assign tries_inc = {1'b0, tries} + 3'd1;

  // State and datapath registers.
  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      state   <= ST_ENTRY;
      entered <= 16'h0000;
      code    <= DEFAULT_CODE;
      cursor  <= CURSOR_LEFT;
      tries   <= 2'd0;
      timer   <= 10'd0;
    end else begin
      state   <= state_next;
      entered <= entered_next;
      code    <= code_next;
      cursor  <= cursor_next;
      tries   <= tries_next;
      timer   <= timer_next;
    end
  end

  // Free-running blink phase, starting in the "on" half after reset.
  always_ff @(posedge clk_100Hz or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Next-state and register updates; enter outranks next, which outranks inc.
  always_comb begin
    state_next   = state;
    entered_next = entered;
    code_next    = code;
    cursor_next  = cursor;
    tries_next   = tries;
    timer_next   = (timer != 10'd0) ? timer - 10'd1 : timer;

    case (state)
      ST_ENTRY: begin
        if (enter_p) begin
          entered_next = 16'h0000;
          cursor_next  = CURSOR_LEFT;
          if (entered == code) begin
            state_next = ST_OPEN;
            tries_next = 2'd0;
            timer_next = UNLOCK_LOAD;
          end else if (tries_inc == TRIES_LIMIT) begin
            state_next = ST_LOCKOUT;
            tries_next = 2'd0;
            timer_next = LOCKOUT_LOAD;
          end else begin
            state_next = ST_FAIL;
            tries_next = tries_inc[1:0];
            timer_next = FAIL_LOAD;
          end
        end else if (next_p) begin
          cursor_next = cursor - 2'd1;
        end else if (inc_p) begin
          entered_next[{cursor, 2'b00} +: 4] = inc_digit;
        end
      end

      ST_OPEN: begin
        // Expiry wins over a simultaneous next so the lock never lingers open.
        if (timer == 10'd0 || enter_p) begin
          state_next   = ST_ENTRY;
          entered_next = 16'h0000;
          cursor_next  = CURSOR_LEFT;
        end else if (next_p) begin
          state_next   = ST_SET;
          entered_next = code;
          cursor_next  = CURSOR_LEFT;
        end
      end

      ST_SET: begin
        if (enter_p) begin
          code_next    = entered;
          state_next   = ST_ENTRY;
          entered_next = 16'h0000;
          cursor_next  = CURSOR_LEFT;
        end else if (next_p) begin
          cursor_next = cursor - 2'd1;
        end else if (inc_p) begin
          entered_next[{cursor, 2'b00} +: 4] = inc_digit;
        end
      end

      ST_FAIL, ST_LOCKOUT: begin
        if (timer == 10'd0) begin
          state_next = ST_ENTRY;
        end
      end

      default: begin
        state_next   = ST_ENTRY;
        entered_next = 16'h0000;
        cursor_next  = CURSOR_LEFT;
      end
    endcase
  end

  // Segment patterns derived from registered state; dp marks the cursor (all digits in SET).
  always_comb begin
    disp = MSG_OFF;
    for (int i = 0; i < 4; i++) begin
      case (state)
        ST_ENTRY, ST_SET: begin
          disp[i*8 +: 8] = bcd_to_seg(entered[i*4 +: 4]);
          if (state == ST_SET || cursor == 2'(i)) begin
            disp[i*8 +: 8] = disp[i*8 +: 8] & SEG_DP_ON;
          end
          if (cursor == 2'(i) && !blink_on) begin
            disp[i*8 +: 8] = SEG_BLANK;
          end
        end
        ST_OPEN:    disp[i*8 +: 8] = MSG_OPEN[i*8 +: 8];
        ST_FAIL:    disp[i*8 +: 8] = MSG_ERR[i*8 +: 8];
        ST_LOCKOUT: disp[i*8 +: 8] = blink_on ? MSG_DASH[i*8 +: 8] : SEG_BLANK;
        default:    disp[i*8 +: 8] = SEG_BLANK;
      endcase
    end
  end

  assign digit0   = disp[7:0];
  assign digit1   = disp[15:8];
  assign digit2   = disp[23:16];
  assign digit3   = disp[31:24];
  assign unlocked = (state == ST_OPEN);
  assign alarm    = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - randomized bench for lock_controller against a behavioural model
module tb_lock_controller;

  logic       clk_100Hz;
  logic       rst;
  logic       btn_inc;
  logic       btn_next;
  logic       btn_enter;
  logic [7:0] digit0;
  logic [7:0] digit1;
  logic [7:0] digit2;
  logic [7:0] digit3;
  logic       unlocked;
  logic       alarm;

  lock_controller dut (
    .clk_100Hz (clk_100Hz),
    .rst       (rst),
    .btn_inc   (btn_inc),
    .btn_next  (btn_next),
    .btn_enter (btn_enter),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .unlocked  (unlocked),
    .alarm     (alarm)
  );

  initial clk_100Hz = 1'b0;
  always #5 clk_100Hz = ~clk_100Hz;

  localparam int M_ENTRY = 0, M_OPEN = 1, M_FAIL = 2, M_LOCK = 3, M_SET = 4;
  localparam logic [2:0] B_INC = 3'b001, B_NEXT = 3'b010, B_ENTER = 3'b100;
  localparam logic [31:0] ERR_TXT  = 32'h86AFAFFF;
  localparam logic [31:0] OPEN_TXT = 32'hC08C86AB;
  localparam logic [31:0] RST_TXT  = 32'h40C0C0C0;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: digits as integers (index 3 = leftmost), remaining ticks, cycle count.
  int m_mode, m_cur, m_tries, m_rem, m_cyc;
  int m_ent [4];
  int m_code [4];
  logic [2:0] h0, h1, h2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_mode = M_ENTRY; m_cur = 3; m_tries = 0; m_rem = 0; m_cyc = 0;
    for (int i = 0; i < 4; i++) m_ent[i] = 0;
    m_code[3] = 1; m_code[2] = 2; m_code[1] = 3; m_code[0] = 4;
    h0 = 3'b000; h1 = 3'b000; h2 = 3'b000;
  endtask

  function automatic bit model_match();
    for (int i = 0; i < 4; i++) if (m_ent[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear_entry();
    for (int i = 0; i < 4; i++) m_ent[i] = 0;
    m_cur = 3;
  endtask

  task automatic model_edit(input logic [2:0] p);
    if (p[1]) m_cur = (m_cur + 3) % 4;
    else if (p[0]) m_ent[m_cur] = (m_ent[m_cur] + 1) % 10;
  endtask

  // One rising edge: the action is driven by levels sampled two and three edges earlier.
  task automatic model_step(input logic [2:0] b);
    logic [2:0] p;
    p = h1 & ~h2;
    h2 = h1; h1 = h0; h0 = b;
    m_cyc++;
    case (m_mode)
      M_ENTRY: begin
        if (p[2]) begin
          if (model_match()) begin
            m_mode = M_OPEN; m_rem = 500; m_tries = 0;
          end else if (m_tries + 1 == 3) begin
            m_mode = M_LOCK; m_rem = 1000; m_tries = 0;
          end else begin
            m_mode = M_FAIL; m_rem = 100; m_tries++;
          end
          model_clear_entry();
        end else model_edit(p);
      end
      M_OPEN: begin
        m_rem--;
        if (m_rem == 0 || p[2]) begin
          m_mode = M_ENTRY; model_clear_entry();
        end else if (p[1]) begin
          m_mode = M_SET;
          for (int i = 0; i < 4; i++) m_ent[i] = m_code[i];
          m_cur = 3;
        end
      end
      M_SET: begin
        if (p[2]) begin
          for (int i = 0; i < 4; i++) m_code[i] = m_ent[i];
          m_mode = M_ENTRY; model_clear_entry();
        end else model_edit(p);
      end
      default: begin
        m_rem--;
        if (m_rem == 0) m_mode = M_ENTRY;
      end
    endcase
  endtask

  function automatic logic [31:0] model_digits();
    logic [7:0] s [4];
    bit blink;
    blink = ((m_cyc / 25) % 2) == 0;
    for (int i = 0; i < 4; i++) begin
      case (m_mode)
        M_OPEN: s[i] = OPEN_TXT[i*8 +: 8];
        M_FAIL: s[i] = ERR_TXT[i*8 +: 8];
        M_LOCK: s[i] = blink ? 8'hBF : 8'hFF;
        default: begin
          s[i] = seg_tab[m_ent[i]];
          if (m_mode == M_SET || i == m_cur) s[i] = s[i] & 8'h7F;
          if (i == m_cur && !blink) s[i] = 8'hFF;
        end
      endcase
    end
    return {s[3], s[2], s[1], s[0]};
  endfunction

  function automatic logic [15:0] model_code16();
    return {4'(m_code[3]), 4'(m_code[2]), 4'(m_code[1]), 4'(m_code[0])};
  endfunction

  // Drive buttons for one cycle, advance the model, compare at the falling edge.
  task automatic tick(input logic [2:0] b);
    {btn_enter, btn_next, btn_inc} = b;
    @(posedge clk_100Hz);
    model_step(b);
    @(negedge clk_100Hz);
    check("digits", {digit3, digit2, digit1, digit0}, model_digits());
    check("unlocked", {31'd0, unlocked}, {31'd0, m_mode == M_OPEN});
    check("alarm", {31'd0, alarm}, {31'd0, m_mode == M_LOCK});
  endtask

  task automatic press(input logic [2:0] b);
    tick(b);
    tick(3'b000);
  endtask

  task automatic submit();
    press(B_ENTER);
    tick(3'b000);
  endtask

  // Dial the target in from the current entry, assuming the cursor starts at the left.
  task automatic type_digits(input logic [15:0] target);
    int t, n;
    for (int i = 3; i >= 0; i--) begin
      t = int'(target[i*4 +: 4]);
      n = (t - m_ent[i] + 10) % 10;
      repeat (n) press(B_INC);
      if (i > 0) press(B_NEXT);
    end
  endtask

  task automatic wait_entry();
    for (int i = 0; i < 1200 && m_mode != M_ENTRY; i++) tick(3'b000);
  endtask

  task automatic go_open();
    wait_entry();
    submit();
    wait_entry();
    type_digits(model_code16());
    submit();
  endtask

  task automatic apply_reset_now();
    #2 rst = 1'b1;
    #1;
    check("rst_digits", {digit3, digit2, digit1, digit0}, RST_TXT);
    check("rst_unlocked", {31'd0, unlocked}, 32'd0);
    check("rst_alarm", {31'd0, alarm}, 32'd0);
    model_reset();
    @(negedge clk_100Hz);
    @(negedge clk_100Hz);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {btn_enter, btn_next, btn_inc} = 3'b000;
    model_reset();
    @(negedge clk_100Hz);
    @(negedge clk_100Hz);
    check("rst_digits", {digit3, digit2, digit1, digit0}, RST_TXT);
    check("rst_unlocked", {31'd0, unlocked}, 32'd0);
    check("rst_alarm", {31'd0, alarm}, 32'd0);
    rst = 1'b0;

    // Blink: cursor digit goes blank after 25 cycles.
    repeat (25) tick(3'b000);
    check("blink_off_digit3", {24'd0, digit3}, 32'h000000FF);

    // Default code opens, then times out after 500 cycles.
    type_digits(16'h1234);
    submit();
    check("open_after_enter", {unlocked, {digit3, digit2, digit1, digit0}}, {1'b1, OPEN_TXT});
    repeat (499) tick(3'b000);
    check("open_before_expiry", {31'd0, unlocked}, 32'd1);
    tick(3'b000);
    check("open_expired", {31'd0, unlocked}, 32'd0);

    // Two wrong codes show Err for 100 cycles each, the third locks out.
    for (int k = 0; k < 2; k++) begin
      submit();
      check("fail_display", {digit3, digit2, digit1, digit0}, ERR_TXT);
      repeat (99) tick(3'b000);
      check("fail_hold", {digit3, digit2, digit1, digit0}, ERR_TXT);
      tick(3'b000);
    end
    submit();
    check("lockout_alarm", {31'd0, alarm}, 32'd1);
    for (int i = 0; i < 999; i++) tick((i < 900) ? 3'($urandom_range(0, 7)) : 3'b000);
    check("lockout_hold", {31'd0, alarm}, 32'd1);
    tick(3'b000);
    check("lockout_exit", {31'd0, alarm}, 32'd0);

    // Change the code to 9005 from OPEN via SET.
    type_digits(16'h1234);
    submit();
    check("open_again", {31'd0, unlocked}, 32'd1);
    press(B_NEXT);
    tick(3'b000);
    type_digits(16'h9005);
    submit();
    type_digits(16'h1234);
    submit();
    check("old_code_rejected", {digit3, digit2, digit1, digit0}, ERR_TXT);
    wait_entry();
    type_digits(16'h9005);
    submit();
    check("new_code_open", {31'd0, unlocked}, 32'd1);
    submit();

    // Ten increments wrap the digit back to 0; inc+enter together acts as enter.
    repeat (10) press(B_INC);
    tick(3'b000);
    check("wrap_digit3", {31'd0, (digit3 == 8'h40 || digit3 == 8'hFF)}, 32'd1);
    press(B_INC | B_ENTER);
    tick(3'b000);
    check("inc_enter_fail", {digit3, digit2, digit1, digit0}, ERR_TXT);
    wait_entry();

    // Reset in the middle of a lockout restores the default code.
    for (int k = 0; k < 3 && m_mode != M_LOCK; k++) begin
      submit();
      if (m_mode != M_LOCK) wait_entry();
    end
    repeat (50) tick(3'b000);
    check("pre_reset_alarm", {31'd0, alarm}, 32'd1);
    apply_reset_now();
    type_digits(16'h1234);
    submit();
    check("code_restored", {31'd0, unlocked}, 32'd1);
    submit();

    // Random button traffic, regularly steered back into OPEN so SET gets exercised.
    for (int r = 0; r < 6; r++) begin
      go_open();
      for (int i = 0; i < 400; i++)
        tick(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
# lock_controller

Code-entry and lock state machine for the digital lock. It takes three push buttons sampled on the 100 Hz display clock and holds the secret code and the four entered BCD digits. It drives the four 8-bit segment patterns consumed directly by the digit multiplexer, which feeds the 7-segment display, together with the lock and alarm outputs.

## Interface
- DEFAULT_CODE, 16'h1234: reset code, 4 BCD nibbles; [15:12] = leftmost digit.
- MAX_TRIES, 3: consecutive wrong codes that trigger lockout.
- UNLOCK_TICKS, 500: OPEN duration in clk_100Hz cycles (5 s).
- FAIL_TICKS, 100: "Err" display duration (1 s).
- LOCKOUT_TICKS, 1000: lockout duration (10 s).
- BLINK_HALF, 25: blink half-period in cycles.
- clk_100Hz  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- btn_inc  in  1  raw button, asynchronous: increment the cursor digit.
- btn_next  in  1  raw button, asynchronous: move the cursor right.
- btn_enter  in  1  raw button, asynchronous: submit.
- digit0..digit3  out  8 each  segment patterns, active-low {dp,g,f,e,d,c,b,a}; digit0 = rightmost, digit3 = leftmost.
- unlocked  out  1  high only in OPEN.
- alarm  out  1  high only in LOCKOUT.

## Operation
- Each button passes through a 2-flop synchronizer, then rising-edge detection, giving a 1-cycle pulse. A held button gives one pulse.
- Simultaneous pulses: priority enter > next > inc. Only one action is taken per cycle.
- States: ENTRY, OPEN, FAIL, LOCKOUT, SET.
- ENTRY
  - inc: cursor digit +1, wraps 9→0.
  - next: cursor moves 3→2→1→0→3.
  - enter, entered = code: OPEN, tries cleared.
  - enter, wrong, tries+1 < MAX_TRIES: FAIL, tries+1.
  - enter, wrong, tries+1 = MAX_TRIES: LOCKOUT, tries cleared.
  - Every enter clears the entered digits to 0 and sets the cursor to 3.
- OPEN
  - Timer expiry or enter: ENTRY.
  - next: SET, with the entered digits loaded from the current code and the cursor at 3.
- SET
  - inc and next act as in ENTRY.
  - enter: code ← entered digits, then ENTRY with digits cleared.
  - No timeout.
- FAIL: all buttons ignored; after FAIL_TICKS, ENTRY.
- LOCKOUT: all buttons ignored; after LOCKOUT_TICKS, ENTRY.
- Segment codes, dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Blank=FF, O=C0, P=8C, E=86, n=AB, r=AF, '-'=BF. dp on = pattern & 7F.
- Display per state:
  - ENTRY: entered digits; dp lit on the cursor digit only; cursor digit is blank (FF) during the blink-off phase.
  - SET: as ENTRY, but dp lit on all four digits.
  - OPEN: "OPEn" = 3..0 C0, 8C, 86, AB.
  - FAIL: "Err " = 86, AF, AF, FF.
  - LOCKOUT: "----" = BF×4 during the blink-on phase, all FF during blink-off.
- Blink phase: free-running counter that toggles every BLINK_HALF cycles; phase is "on" after reset.

## Timing
- A button high before edge N is in flop 1 at N and flop 2 at N+1. The action's state/register update occurs at edge N+2. Outputs follow within that cycle; digits are combinational from registered state.
- The state timer loads on state entry. A state lasting T ticks exits at the T-th edge after entry.
- Reset, any time including mid-lockout: ENTRY, code=DEFAULT_CODE, entered=0000, cursor=3, tries=0, timers=0, blink phase on, synchronizers cleared.
- Reset output values: digit3=40, digit2=digit1=digit0=C0, unlocked=0, alarm=0.
- tries is 2 bits; the timer is 10 bits wide, sized for LOCKOUT_TICKS. Comparisons are on full 16-bit BCD.

## Structure
- Package lock_pkg: state enum; segment constants SEG_BLANK, SEG_O, SEG_P, SEG_E, SEG_N, SEG_R, SEG_DASH; function bcd_to_seg.
- Sub-module button_edge (synchronizer + edge pulse), instantiated three times.

## Test plan
- Reset → digits 40,C0,C0,C0; unlocked=0; alarm=0. Then 25 cycles → digit3 reaches FF (blink off).
- Enter 1,2,3,4 with inc/next, then enter → unlocked=1 and display "OPEn" two edges after the press. After 500 cycles → unlocked=0, ENTRY.
- Code 0000 entered three times → FAIL ("Err ") for 100 cycles twice. On the third → alarm=1 for 1000 cycles, buttons ignored, then ENTRY with tries=0.
- Unlock, press next, set 9,0,0,5, press enter. Then 1234 → FAIL, and 9005 → OPEN.
- inc ten times on one digit → value 0 (wrap). Simultaneous inc+enter → only enter acts.
- Assert rst during LOCKOUT → alarm=0 immediately, code back to 1234.
